// File: rtl/mms_verify_sched_if.sv
// Transmit-process handshake for MAC-merge verify/respond mPackets.
// Level requests out, one-cycle completion pulses back.
interface mms_verify_sched_if;
    logic send_v;
    logic send_r;
    logic tx_v_done;
    logic tx_r_done;

    modport master (
        output send_v,
        output send_r,
        input  tx_v_done,
        input  tx_r_done
    );

    modport slave (
        input  send_v,
        input  send_r,
        output tx_v_done,
        output tx_r_done
    );
endinterface

// File: rtl/mms_verify_sched.sv
// 802.3br MAC-merge verify/respond scheduler, verify timer and pActive.
// Optional MMS_VERIFY_STATS_EN adds saturating transmit/failure counters.
module mms_verify_sched #(
    parameter logic [19:0] VERIFY_TIME  = 20'd125000,
    parameter int          VERIFY_LIMIT = 3
) (
    input  logic       clk,
    input  logic       reset_begin,
    input  logic       pEnable,
    input  logic       disableVerify,
    input  logic       link_fail,
    input  logic       rcv_v,
    input  logic       rcv_r,
    mms_verify_sched_if.master tx,
    output logic       pActive,
    output logic [2:0] verify_status,
    output logic [2:0] verify_state
`ifdef MMS_VERIFY_STATS_EN
    ,
    output logic [15:0] verify_tx_cnt,
    output logic [15:0] respond_tx_cnt,
    output logic [15:0] verify_fail_cnt
`endif
);

    typedef enum logic [2:0] {
        INIT_VERIFICATION = 3'd0,
        VERIFICATION_IDLE = 3'd1,
        SEND_VERIFY       = 3'd2,
        WAIT_FOR_RESPONSE = 3'd3,
        VERIFIED          = 3'd4,
        VERIFY_FAIL       = 3'd5
    } stateT;

    localparam logic [2:0] ST_INITIAL   = 3'd0;
    localparam logic [2:0] ST_VERIFYING = 3'd1;
    localparam logic [2:0] ST_SUCCEEDED = 3'd2;
    localparam logic [2:0] ST_FAILED    = 3'd3;
    localparam logic [2:0] ST_DISABLED  = 3'd4;

    localparam logic [2:0]  LIMIT    = 3'(VERIFY_LIMIT);
    localparam logic [19:0] TIME_END = VERIFY_TIME - 20'd1;

    stateT       state;
    logic [2:0]  verifyCnt;
    logic [19:0] timer;
    logic        override;
    logic        timerDone;

    assign override  = link_fail | ~pEnable | disableVerify;
    assign timerDone = (timer == TIME_END);
    assign verify_state = state;

    always_ff @(posedge clk) begin
        if (reset_begin) begin
            state     <= INIT_VERIFICATION;
            verifyCnt <= 3'd0;
            timer     <= 20'd0;
            tx.send_v <= 1'b0;
        end else if (override) begin
            state     <= INIT_VERIFICATION;
            verifyCnt <= 3'd0;
            timer     <= 20'd0;
            tx.send_v <= 1'b0;
        end else begin
            unique case (state)
                INIT_VERIFICATION: begin
                    verifyCnt <= 3'd0;
                    state     <= VERIFICATION_IDLE;
                end
                VERIFICATION_IDLE: begin
                    verifyCnt <= verifyCnt + 3'd1;
                    tx.send_v <= 1'b1;
                    state     <= SEND_VERIFY;
                end
                SEND_VERIFY: begin
                    if (tx.tx_v_done) begin
                        tx.send_v <= 1'b0;
                        timer     <= 20'd0;
                        state     <= WAIT_FOR_RESPONSE;
                    end
                end
                WAIT_FOR_RESPONSE: begin
                    // a response landing on the last timer cycle still counts
                    if (rcv_r) begin
                        state <= VERIFIED;
                    end else if (timerDone) begin
                        if (verifyCnt < LIMIT) begin
                            verifyCnt <= verifyCnt + 3'd1;
                            tx.send_v <= 1'b1;
                            state     <= SEND_VERIFY;
                        end else begin
                            state <= VERIFY_FAIL;
                        end
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end
                VERIFIED:    state <= VERIFIED;
                VERIFY_FAIL: state <= VERIFY_FAIL;
                default:     state <= INIT_VERIFICATION;
            endcase
        end
    end

    // rcv_v wins over tx_r_done so a fresh verify is always answered
    always_ff @(posedge clk) begin
        if (reset_begin)
            tx.send_r <= 1'b0;
        else if (link_fail || !pEnable)
            tx.send_r <= 1'b0;
        else if (rcv_v)
            tx.send_r <= 1'b1;
        else if (tx.tx_r_done)
            tx.send_r <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset_begin) begin
            pActive       <= 1'b0;
            verify_status <= ST_INITIAL;
        end else begin
            pActive <= pEnable & ~link_fail
                     & (disableVerify | (state == VERIFIED));
            if (disableVerify && pEnable) begin
                verify_status <= ST_DISABLED;
            end else begin
                unique case (state)
                    VERIFIED:          verify_status <= ST_SUCCEEDED;
                    VERIFY_FAIL:       verify_status <= ST_FAILED;
                    SEND_VERIFY,
                    WAIT_FOR_RESPONSE: verify_status <= ST_VERIFYING;
                    default:           verify_status <= ST_INITIAL;
                endcase
            end
        end
    end

`ifdef MMS_VERIFY_STATS_EN
    logic [15:0] verifyTxCnt;
    logic [15:0] respondTxCnt;
    logic [15:0] verifyFailCnt;
    logic        failEntry;

    assign failEntry = ~override & (state == WAIT_FOR_RESPONSE)
                     & ~rcv_r & timerDone & (verifyCnt >= LIMIT);

    always_ff @(posedge clk) begin
        if (reset_begin) begin
            verifyTxCnt   <= 16'd0;
            respondTxCnt  <= 16'd0;
            verifyFailCnt <= 16'd0;
        end else begin
            if (tx.tx_v_done && verifyTxCnt != 16'hFFFF)
                verifyTxCnt <= verifyTxCnt + 16'd1;
            if (tx.tx_r_done && respondTxCnt != 16'hFFFF)
                respondTxCnt <= respondTxCnt + 16'd1;
            if (failEntry && verifyFailCnt != 16'hFFFF)
                verifyFailCnt <= verifyFailCnt + 16'd1;
        end
    end

    assign verify_tx_cnt   = verifyTxCnt;
    assign respond_tx_cnt  = respondTxCnt;
    assign verify_fail_cnt = verifyFailCnt;
`endif

endmodule

// File: tb/tb_mms_verify_sched.sv
// Directed bench for mms_verify_sched with VERIFY_TIME=100, VERIFY_LIMIT=3.
// Statistics checks compile in only with MMS_VERIFY_STATS_EN.
module tb_mms_verify_sched;

    logic       clk;
    logic       reset_begin;
    logic       pEnable;
    logic       disableVerify;
    logic       link_fail;
    logic       rcv_v;
    logic       rcv_r;
    logic       pActive;
    logic [2:0] verify_status;
    logic [2:0] verify_state;
`ifdef MMS_VERIFY_STATS_EN
    logic [15:0] verify_tx_cnt;
    logic [15:0] respond_tx_cnt;
    logic [15:0] verify_fail_cnt;
`endif

    int nChecks = 0;
    int nFails  = 0;

    mms_verify_sched_if bus ();

    mms_verify_sched #(
        .VERIFY_TIME  (20'd100),
        .VERIFY_LIMIT (3)
    ) dut (
        .clk           (clk),
        .reset_begin   (reset_begin),
        .pEnable       (pEnable),
        .disableVerify (disableVerify),
        .link_fail     (link_fail),
        .rcv_v         (rcv_v),
        .rcv_r         (rcv_r),
        .tx            (bus.master),
        .pActive       (pActive),
        .verify_status (verify_status),
        .verify_state  (verify_state)
`ifdef MMS_VERIFY_STATS_EN
        ,
        .verify_tx_cnt   (verify_tx_cnt),
        .respond_tx_cnt  (respond_tx_cnt),
        .verify_fail_cnt (verify_fail_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseTxV();
        bus.tx_v_done = 1'b1;
        step(1);
        bus.tx_v_done = 1'b0;
    endtask

    task automatic pulseTxR();
        bus.tx_r_done = 1'b1;
        step(1);
        bus.tx_r_done = 1'b0;
    endtask

    task automatic pulseRcvV();
        rcv_v = 1'b1;
        step(1);
        rcv_v = 1'b0;
    endtask

    // three attempts, each acked at once and left to time out
    task automatic attempts(input bit race);
        for (int a = 1; a <= 3; a++) begin
            chk("sendV_on", 32'(bus.send_v), 1);
            chk("verifyCnt", 32'(dut.verifyCnt), 32'(a));
            pulseTxV();
            chk("sendV_off", 32'(bus.send_v), 0);
            chk("waitState", 32'(verify_state), 3);
            step(99);
            chk("waitHold", 32'(verify_state), 3);
            if (race && a == 3) rcv_r = 1'b1;
            step(1);
            rcv_r = 1'b0;
            if (a < 3)
                chk("retryState", 32'(verify_state), 2);
            else
                chk("endState", 32'(verify_state), race ? 4 : 5);
        end
    endtask

    initial begin
        reset_begin   = 1'b1;
        pEnable       = 1'b0;
        disableVerify = 1'b0;
        link_fail     = 1'b0;
        rcv_v         = 1'b0;
        rcv_r         = 1'b0;
        bus.tx_v_done = 1'b0;
        bus.tx_r_done = 1'b0;
        step(2);
        reset_begin = 1'b0;
        chk("rstSendV", 32'(bus.send_v), 0);
        chk("rstSendR", 32'(bus.send_r), 0);
        chk("rstPActive", 32'(pActive), 0);
        chk("rstStatus", 32'(verify_status), 0);
        chk("rstState", 32'(verify_state), 0);

        // happy path
        pEnable = 1'b1;
        step(1);
        chk("idle", 32'(verify_state), 1);
        step(1);
        chk("send", 32'(verify_state), 2);
        chk("sendV1", 32'(bus.send_v), 1);
        step(3);
        chk("sendVHold", 32'(bus.send_v), 1);
        chk("statusVer", 32'(verify_status), 1);
        pulseTxV();
        chk("sendVDrop", 32'(bus.send_v), 0);
        step(9);
        rcv_r = 1'b1;
        step(1);
        rcv_r = 1'b0;
        chk("verified", 32'(verify_state), 4);
        chk("pActLag", 32'(pActive), 0);
        step(1);
        chk("pActive1", 32'(pActive), 1);
        chk("statusOk", 32'(verify_status), 2);
        chk("cntHappy", 32'(dut.verifyCnt), 1);

        // link_fail override, then re-verify to failure
        link_fail = 1'b1;
        step(1);
        link_fail = 1'b0;
        chk("lfPActive", 32'(pActive), 0);
        chk("lfState", 32'(verify_state), 0);
        step(2);
        attempts(1'b0);
        step(1);
        chk("failStatus", 32'(verify_status), 3);
        chk("failPActive", 32'(pActive), 0);
        step(5);
        chk("failAbsorb", 32'(verify_state), 5);
`ifdef MMS_VERIFY_STATS_EN
        chk("vTxCnt", 32'(verify_tx_cnt), 4);
        chk("vFailCnt", 32'(verify_fail_cnt), 1);
`endif

        // disableVerify
        disableVerify = 1'b1;
        step(1);
        chk("disState", 32'(verify_state), 0);
        chk("disPActive", 32'(pActive), 1);
        chk("disStatus", 32'(verify_status), 4);
        step(5);
        chk("disNoSendV", 32'(bus.send_v), 0);
        chk("disHold", 32'(pActive), 1);
        disableVerify = 1'b0;
        step(1);
        chk("reenPActive", 32'(pActive), 0);
        step(1);

        // rcv_r on the final timer cycle of attempt 3
        attempts(1'b1);
        step(1);
        chk("raceStatus", 32'(verify_status), 2);
        chk("racePActive", 32'(pActive), 1);

        // respond path
        pulseRcvV();
        chk("sendR1", 32'(bus.send_r), 1);
        step(2);
        pulseRcvV();
        chk("sendRCoal", 32'(bus.send_r), 1);
        pulseTxR();
        chk("sendRClr", 32'(bus.send_r), 0);
        pulseRcvV();
        rcv_v = 1'b1;
        bus.tx_r_done = 1'b1;
        step(1);
        rcv_v = 1'b0;
        bus.tx_r_done = 1'b0;
        chk("sendROwed", 32'(bus.send_r), 1);
        pulseTxR();
        chk("sendRDone", 32'(bus.send_r), 0);
        pulseRcvV();
        link_fail = 1'b1;
        step(1);
        chk("sendRLink", 32'(bus.send_r), 0);
        pulseRcvV();
        chk("sendRLinkV", 32'(bus.send_r), 0);
        link_fail = 1'b0;
        disableVerify = 1'b1;
        pulseRcvV();
        chk("sendRDisV", 32'(bus.send_r), 1);
`ifdef MMS_VERIFY_STATS_EN
        chk("rTxCnt", 32'(respond_tx_cnt), 3);
`endif

        // reset mid-operation, late completion ignored
        reset_begin = 1'b1;
        step(1);
        reset_begin = 1'b0;
        chk("mrSendR", 32'(bus.send_r), 0);
        chk("mrPActive", 32'(pActive), 0);
        chk("mrStatus", 32'(verify_status), 0);
        disableVerify = 1'b0;
        pEnable = 1'b0;
        pulseTxR();
        chk("mrLateR", 32'(bus.send_r), 0);

`ifdef MMS_VERIFY_STATS_EN
        chk("mrVTxCnt", 32'(verify_tx_cnt), 0);
        force dut.verifyTxCnt = 16'hFFFF;
        step(1);
        release dut.verifyTxCnt;
        pulseTxV();
        chk("vTxSat", 32'(verify_tx_cnt), 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mms_verify_sched.md
Name: mms_verify_sched

Overview:
- Verify/respond scheduler for the 802.3br MAC-merge transmit process.
- Sequences SMD-V (verify) and SMD-R (respond) mPacket requests to the transmit process via the send_v/send_r level-handshake.
- Runs the verify timer and retry count, and derives pActive, which the transmit process samples into pAllow.
- Sits beside the transmit process in the MMS, fed by receive-side verify/respond detection.

Parameters:
- VERIFY_TIME, 20'd125000: verify timer period in clk cycles (1 ms at 125 MHz); must be >= 2.
- VERIFY_LIMIT, 3: maximum verify attempts before failure; range 1..7.

Ports:
- clk  in  1  block clock
- reset_begin  in  1  synchronous active-high reset
- pEnable  in  1  preemption enabled by management
- disableVerify  in  1  management: skip verification
- link_fail  in  1  PHY link down
- rcv_v  in  1  1-cycle pulse: valid verify mPacket received
- rcv_r  in  1  1-cycle pulse: valid respond mPacket received
- tx_v_done  in  1  1-cycle pulse: transmit process finished the verify mPacket
- tx_r_done  in  1  1-cycle pulse: transmit process finished the respond mPacket
- send_v  out  1  request verify mPacket transmission
- send_r  out  1  request respond mPacket transmission
- pActive  out  1  preemption operationally active
- verify_status  out  3  0 INITIAL, 1 VERIFYING, 2 SUCCEEDED, 3 FAILED, 4 DISABLED
- verify_state  out  3  current FSM state encoding, for debug

Behaviour:
- All outputs are registered. Reset values: send_v=0, send_r=0, pActive=0, verify_status=0, verify_state=INIT_VERIFICATION, verifyCnt=0, timer=0.
- FSM state encodings:
  - INIT_VERIFICATION=0, VERIFICATION_IDLE=1, SEND_VERIFY=2, WAIT_FOR_RESPONSE=3, VERIFIED=4, VERIFY_FAIL=5.
- Global override, highest priority, evaluated every cycle: link_fail | !pEnable | disableVerify forces next state INIT_VERIFICATION. This also clears verifyCnt and the timer, and drops send_v the following cycle.
- INIT_VERIFICATION: verifyCnt=0. Leave to VERIFICATION_IDLE when pEnable & !disableVerify & !link_fail.
- VERIFICATION_IDLE: go to SEND_VERIFY next cycle.
- SEND_VERIFY:
  - On entry, verifyCnt increments (3-bit) and send_v goes to 1.
  - send_v holds until tx_v_done.
  - On tx_v_done: send_v=0, timer cleared, move to WAIT_FOR_RESPONSE.
- WAIT_FOR_RESPONSE:
  - Timer increments each cycle; done when timer==VERIFY_TIME-1.
  - rcv_r → VERIFIED. rcv_r wins if it coincides with timer done.
  - Timer done & verifyCnt<VERIFY_LIMIT → SEND_VERIFY.
  - Timer done & verifyCnt==VERIFY_LIMIT → VERIFY_FAIL.
- VERIFIED, VERIFY_FAIL: absorbing; exit only via the global override or reset.
- rcv_r in any state other than WAIT_FOR_RESPONSE: ignored.
- Respond path, independent of the FSM:
  - rcv_v & pEnable & !link_fail sets send_r=1 next cycle.
  - send_r clears on tx_r_done.
  - rcv_v while send_r is already 1 coalesces: no queueing.
  - rcv_v and tx_r_done in the same cycle leave send_r=1, so a new respond is owed.
  - link_fail or !pEnable clears send_r.
  - The respond path runs even when disableVerify=1.
- send_v and send_r may both be 1; the transmit process gives send_r priority.
- pActive (registered) = pEnable & !link_fail & (disableVerify | state==VERIFIED).
- verify_status:
  - DISABLED if disableVerify & pEnable.
  - Otherwise SUCCEEDED in VERIFIED, FAILED in VERIFY_FAIL, VERIFYING in SEND_VERIFY or WAIT_FOR_RESPONSE, INITIAL otherwise.
- Reset asserted mid-operation: all registers return to reset values on the next clk edge. A pending tx_*_done arriving after reset is ignored.

Optional Feature:
- Macro: MMS_VERIFY_STATS_EN.
- When defined, adds three 16-bit saturating output counters, each cleared by reset_begin only:
  - verify_tx_cnt: increments on tx_v_done.
  - respond_tx_cnt: increments on tx_r_done.
  - verify_fail_cnt: increments on entry to VERIFY_FAIL.
- Counters hold at 16'hFFFF.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Happy path, VERIFY_TIME=100. pEnable=1, disableVerify=0. After send_v, pulse tx_v_done, then rcv_r 10 cycles later → verify_status=2 and pActive=1 one cycle after VERIFIED; verifyCnt=1.
2. Retry to fail, VERIFY_LIMIT=3. Never send rcv_r, ack each send_v → exactly 3 send_v assertions spaced by 100-cycle waits, then VERIFY_FAIL, verify_status=3, pActive=0.
3. Boundary race: rcv_r in the same cycle as timer done on attempt 3 → VERIFIED, not VERIFY_FAIL.
4. Respond path:
   - rcv_v twice before tx_r_done → a single send_r level, cleared by one tx_r_done.
   - rcv_v coincident with tx_r_done → send_r stays 1.
5. Override: link_fail pulse while VERIFIED → pActive=0 next cycle, FSM to INIT, then re-verifies with verifyCnt restarting at 1. disableVerify=1 → pActive=1 with no send_v, verify_status=4.
6. MMS_VERIFY_STATS_EN defined: scenario 2 → verify_tx_cnt=3, verify_fail_cnt=1. Force counter to FFFF; one more event → stays FFFF.
